mips_stage_controller: RTL and testbench
========================================

// Module: mips_stage_controller
// PURPOSE
//  Multi-cycle sequencer for the Harvard MIPS core. Steps a one-hot FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
//  cycle, gates all side-effecting strobes (IR load, PC update, reg write, data read/write) to the right stage,
//  stalls on data-memory wait, skips MEMORY for non-memory instrs, and drops `active` on halt (jump to 0).
// PARAMETERS
//  SKIP_MEM     1   1: EXECUTE->WRITEBACK when instr is neither load nor store; 0: always visit MEMORY
//  MEM_TIMEOUT  15  max consecutive mem_wait cycles in MEMORY before fault-halt; 0 disables timeout
//  CNT_W        32  width of cycle/instruction counters
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      synchronous, active-high
//  clk_enable    in   1      global advance qualifier; 0 freezes all state
//  dec_is_load   in   1      decoder: instr is a load (sampled in DECODE)
//  dec_is_store  in   1      decoder: instr is a store (sampled in DECODE)
//  dec_writes_reg in  1      decoder: instr writes GPR (sampled in DECODE)
//  dec_branch    in   1      decoder: control transfer taken (sampled in DECODE)
//  dec_halt      in   1      decoder: jump target == 0 (sampled in DECODE)
//  mem_wait      in   1      data memory not ready; valid only in MEMORY
//  stage         out  5      one-hot {WB,MEM,EX,DEC,FETCH}; 0 while halted
//  active        out  1      1 while running, 0 once halted
//  fault         out  1      sticky: memory timeout or load&store both set
//  ir_en         out  1      latch instr_readdata (FETCH & clk_enable)
//  pc_en         out  1      advance PC (WRITEBACK & clk_enable)
//  branch_en     out  1      PC takes branch target (pc_en & latched branch)
//  reg_write_en  out  1      GPR write (WRITEBACK & clk_enable & latched writes_reg)
//  data_read     out  1      MEMORY & latched load (not gated by clk_enable)
//  data_write    out  1      MEMORY & latched store & clk_enable & !mem_wait
//  cycle_count   out  CNT_W  clk_enable cycles since reset while active
//  instr_count   out  CNT_W  instructions retired (WRITEBACK completions)
// BEHAVIOUR
//  Reset (sync, overrides clk_enable): state=FETCH (stage=5'b00001), active=1, fault=0, counters=0,
//   latched decode flags=0. All strobes then follow their equations (only ir_en may be 1).
//  State only moves on posedge with clk_enable=1; with clk_enable=0 state, flags, counters hold.
//  Transitions: FETCH->DECODE; DECODE->EXECUTE (latch dec_* flags); EXECUTE->MEMORY if load|store or
//   SKIP_MEM=0, else ->WRITEBACK; MEMORY->MEMORY while mem_wait, else ->WRITEBACK;
//   WRITEBACK->HALTED if latched halt or fault, else ->FETCH. HALTED is absorbing until reset.
//  Normal latency: 5 enabled cycles for load/store, 4 for ALU/branch with SKIP_MEM=1.
//  Load and store both set in DECODE: treat as store, set fault; instr completes, then HALTED.
//  mem_wait counter: clears on MEMORY entry; counts cycles with mem_wait=1; when it reaches MEM_TIMEOUT,
//   set fault and force WRITEBACK with reg_write_en suppressed for that instr, then HALTED.
//  HALTED: stage=0, active=0, all strobes 0, counters frozen. Halt instr itself retires (instr_count++,
//   its reg write/branch still occur in WRITEBACK).
//  Counters wrap modulo 2^CNT_W; cycle_count increments on every enabled cycle with active=1.
//  mem_wait outside MEMORY is ignored. Reset mid-MEMORY: no further data_write; back to FETCH next cycle.
// TESTING
//  ALU instr (writes_reg=1), no wait -> stage 01,02,04,10; reg_write_en 1 cycle at WB; instr_count=1 after 4.
//  Load with mem_wait high 3 cycles -> MEMORY held 4 cycles, data_read high all 4; WB at cycle 8.
//  Store, clk_enable toggled 1/0 -> stage advances only on enabled edges; data_write never high when ce=0.
//  dec_halt=1 on ALU instr -> WB strobes once, then stage=0, active=0, cycle_count frozen at 4.
//  MEM_TIMEOUT=15, mem_wait stuck 1 -> fault=1 after 15 wait cycles, no reg write, active=0.
//  Reset asserted in MEMORY of store with ce=0 -> next cycle stage=00001, active=1, counters 0.

Source files
------------

// File: rtl/mips_stage_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the Harvard MIPS core.
// Ports: clk, reset (sync, high), clk_enable, dec_* decode flags, mem_wait -> stage, active, fault, strobes, counters.
module mips_stage_controller #(
  parameter bit SKIP_MEM    = 1'b1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_writes_reg,
  input  logic             dec_branch,
  input  logic             dec_halt,
  input  logic             mem_wait,
  output logic [4:0]       stage,
  output logic             active,
  output logic             fault,
  output logic             ir_en,
  output logic             pc_en,
  output logic             branch_en,
  output logic             reg_write_en,
  output logic             data_read,
  output logic             data_write,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam int WW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WLIM = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WONE = WW'(1);
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  state_t state_q, state_d;

  logic ld_q, st_q, wr_q, br_q, hlt_q;
  logic tmo_q, fault_q;
  logic [WW-1:0] wait_q, wait_next;
  logic timeout_hit;
  logic [CNT_W-1:0] cycle_q, instr_q;

  // Consecutive-wait count reaching the limit ends the access.
  assign wait_next = wait_q + WONE;
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait &&
                       (wait_next == WLIM);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ld_q || st_q || !SKIP_MEM)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (!mem_wait || timeout_hit)
          state_d = S_WB;
      end
      S_WB: begin
        if (hlt_q || fault_q)
          state_d = S_HALT;
        else
          state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      wr_q    <= 1'b0;
      br_q    <= 1'b0;
      hlt_q   <= 1'b0;
      tmo_q   <= 1'b0;
      fault_q <= 1'b0;
      wait_q  <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        // Conflicting load+store runs as a store.
        ld_q  <= dec_is_load & ~dec_is_store;
        st_q  <= dec_is_store;
        wr_q  <= dec_writes_reg;
        br_q  <= dec_branch;
        hlt_q <= dec_halt;
        tmo_q <= 1'b0;
        if (dec_is_load && dec_is_store)
          fault_q <= 1'b1;
      end
      if (state_q == S_EXEC)
        wait_q <= '0;
      if (state_q == S_MEM && mem_wait) begin
        wait_q <= wait_next;
        if (timeout_hit) begin
          fault_q <= 1'b1;
          tmo_q   <= 1'b1;
        end
      end
      if (state_q != S_HALT)
        cycle_q <= cycle_q + CONE;
      if (state_q == S_WB)
        instr_q <= instr_q + CONE;
    end
  end

  always_comb begin
    stage = 5'b00000;
    unique case (state_q)
      S_FETCH:  stage = 5'b00001;
      S_DECODE: stage = 5'b00010;
      S_EXEC:   stage = 5'b00100;
      S_MEM:    stage = 5'b01000;
      S_WB:     stage = 5'b10000;
      default:  stage = 5'b00000;
    endcase
  end

  assign active       = (state_q != S_HALT);
  assign fault        = fault_q;
  assign ir_en        = stage[0] & clk_enable;
  assign pc_en        = stage[4] & clk_enable;
  assign branch_en    = pc_en & br_q;
  // A timed-out access must not commit stale load data.
  assign reg_write_en = pc_en & wr_q & ~tmo_q;
  assign data_read    = stage[3] & ld_q;
  // Reset in MEMORY must not let a store slip out.
  assign data_write   = stage[3] & st_q & clk_enable &
                        ~mem_wait & ~reset;
  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;

endmodule

// File: tb/tb_mips_stage_controller.sv
// Self-checking bench for mips_stage_controller.
// Expected per-cycle strobes are queued with stimulus and popped at negedge.
module tb_mips_stage_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        ld = 1'b0, st = 1'b0, wr = 1'b0;
  logic        br = 1'b0, hlt = 1'b0, mw = 1'b0;
  logic [4:0]  stage;
  logic        active, fault, ir_en, pc_en, branch_en;
  logic        reg_write_en, data_read, data_write;
  logic [31:0] cycle_count, instr_count;
  logic [12:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic ce;
    logic mw;
  } stim_t;

  stim_t       stim_q[$];
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  mips_stage_controller #(
    .SKIP_MEM(1'b1),
    .MEM_TIMEOUT(15),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(ce),
    .dec_is_load(ld),
    .dec_is_store(st),
    .dec_writes_reg(wr),
    .dec_branch(br),
    .dec_halt(hlt),
    .mem_wait(mw),
    .stage(stage),
    .active(active),
    .fault(fault),
    .ir_en(ir_en),
    .pc_en(pc_en),
    .branch_en(branch_en),
    .reg_write_en(reg_write_en),
    .data_read(data_read),
    .data_write(data_write),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  assign obs = {stage, active, fault, ir_en, pc_en,
                branch_en, reg_write_en, data_read, data_write};

  function automatic logic [12:0] e(
    logic [4:0] s, logic f, logic i, logic p,
    logic b, logic r, logic d, logic w);
    return {s, |s, f, i, p, b, r, d, w};
  endfunction

  task automatic add(logic c, logic m, logic [12:0] x);
    stim_t s;
    s.ce = c;
    s.mw = m;
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  task automatic set_instr(logic l, logic s, logic w,
                           logic b, logic h);
    ld = l; st = s; wr = w; br = b; hlt = h;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce = 1'b0;
    mw = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_instr(0, 0, 0, 0, 0);
    do_reset();
    ce = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== e(5'b00001, 0, 1, 0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want %b",
               obs, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    end
    n_cmp++;
    if (cycle_count !== 0 || instr_count !== 0) begin
      n_bad++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0",
               cycle_count, instr_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(0, 0, 1, 0, 0);
    do_reset();
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b10000, 0, 0, 1, 0, 1, 0, 0));
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL alu cyc%0d: got %b want %b", k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 1 || cycle_count !== 5) begin
      n_bad++;
      $display("FAIL alu_counts: got %0d/%0d want 1/5",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_load_wait();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(1, 0, 1, 0, 0);
    do_reset();
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      add(1, 1, e(5'b01000, 0, 0, 0, 0, 0, 1, 0));
    add(1, 0, e(5'b01000, 0, 0, 0, 0, 0, 1, 0));
    add(1, 0, e(5'b10000, 0, 0, 1, 0, 1, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL load_wait cyc%0d: got %b want %b",
                 k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 1 || cycle_count !== 8) begin
      n_bad++;
      $display("FAIL load_counts: got %0d/%0d want 1/8",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_store_ce();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(0, 1, 0, 0, 0);
    do_reset();
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(0, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, e(5'b01000, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b01000, 0, 0, 0, 0, 0, 0, 1));
    add(0, 0, e(5'b10000, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b10000, 0, 0, 1, 0, 0, 0, 0));
    add(0, 0, e(5'b00001, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL store_ce cyc%0d: got %b want %b",
                 k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 1 || cycle_count !== 6) begin
      n_bad++;
      $display("FAIL store_counts: got %0d/%0d want 1/6",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_halt();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(0, 0, 1, 1, 1);
    do_reset();
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b10000, 0, 0, 1, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      add(1, 0, e(5'b00000, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL halt cyc%0d: got %b want %b", k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 1 || cycle_count !== 4) begin
      n_bad++;
      $display("FAIL halt_counts: got %0d/%0d want 1/4",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(1, 0, 1, 0, 0);
    do_reset();
    add(1, 1, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(1, 1, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 15; i++)
      add(1, 1, e(5'b01000, 0, 0, 0, 0, 0, 1, 0));
    add(1, 1, e(5'b10000, 1, 0, 1, 0, 0, 0, 0));
    add(1, 1, e(5'b00000, 1, 0, 0, 0, 0, 0, 0));
    add(1, 1, e(5'b00000, 1, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL timeout cyc%0d: got %b want %b",
                 k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 1 || cycle_count !== 19) begin
      n_bad++;
      $display("FAIL timeout_counts: got %0d/%0d want 1/19",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_load_store();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(1, 1, 0, 0, 0);
    do_reset();
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00100, 1, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b01000, 1, 0, 0, 0, 0, 0, 1));
    add(1, 0, e(5'b10000, 1, 0, 1, 0, 0, 0, 0));
    add(1, 0, e(5'b00000, 1, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL load_store cyc%0d: got %b want %b",
                 k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 1 || cycle_count !== 5) begin
      n_bad++;
      $display("FAIL ls_counts: got %0d/%0d want 1/5",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(0, 0, 1, 0, 0);
    do_reset();
    for (int j = 0; j < 2; j++) begin
      add(1, 1, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
      add(1, 1, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
      add(1, 1, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
      add(1, 1, e(5'b10000, 0, 0, 1, 0, 1, 0, 0));
    end
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL b2b cyc%0d: got %b want %b", k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (instr_count !== 2 || cycle_count !== 8) begin
      n_bad++;
      $display("FAIL b2b_counts: got %0d/%0d want 2/8",
               instr_count, cycle_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    stim_t s;
    logic [12:0] x;
    int k = 0;
    set_instr(0, 1, 0, 0, 0);
    do_reset();
    add(1, 0, e(5'b00001, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00010, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, e(5'b00100, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, e(5'b01000, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      ce = s.ce; mw = s.mw;
      @(negedge clk);
      n_cmp++;
      if (obs !== x) begin
        n_bad++;
        $display("FAIL rst_mem cyc%0d: got %b want %b",
                 k, obs, x);
      end
      k++;
      @(posedge clk);
      #1;
    end
    ce = 1'b0;
    mw = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (data_write !== 1'b0 || stage !== 5'b01000) begin
      n_bad++;
      $display("FAIL rst_mem_hold: got dw=%b st=%b want 0/01000",
               data_write, stage);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== e(5'b00001, 0, 0, 0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL rst_mem_after: got %b want %b",
               obs, e(5'b00001, 0, 0, 0, 0, 0, 0, 0));
    end
    n_cmp++;
    if (cycle_count !== 0 || instr_count !== 0) begin
      n_bad++;
      $display("FAIL rst_mem_counts: got %0d/%0d want 0/0",
               cycle_count, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_ce();
    test_halt();
    test_timeout();
    test_load_store();
    test_back_to_back();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
